mult_acc: RTL and testbench

- Downstream consumer of the sequential shift-add multiplier's result port.
- Sums groups of GROUP unsigned products into one accumulated value and presents each closed sum on a valid/ready output.
- Drives a ready back to the operand feeder so no product is issued whose sum could not be stored.
- Intended chain: feeder -> multiplier -> mult_acc -> consumer.

---
 rtl/mult_acc_pkg.sv | 12 +
 rtl/mult_acc_outreg.sv | 43 ++++
 rtl/mult_acc.sv | 56 +++++
 tb/tb_mult_acc.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_acc_pkg.sv
// mult_acc_pkg: shared width helper, default count width and output-state encoding
package mult_acc_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  localparam int GROUP_DEF = 4;
  localparam int CNT_W = clog2(GROUP_DEF + 1);
  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_e;
endpackage

// File: rtl/mult_acc_outreg.sv
// mult_acc_outreg: single-entry valid/ready sum holder with load, drop and sticky overrun
module mult_acc_outreg
  import mult_acc_pkg::*;
#(
  parameter int W  = 16,
  parameter int CW = 3
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic [W-1:0]  i_sum,
  input  logic [CW-1:0] i_cnt,
  input  logic          i_ready,
  output logic [W-1:0]  o_sum,
  output logic [CW-1:0] o_cnt,
  output logic          o_valid,
  output logic          o_overrun
);
  out_state_e state, state_n;
  logic hs, take;
  assign o_valid = state == OUT_FULL;
  assign hs = o_valid && i_ready;
  assign take = i_load && (!o_valid || hs);
  // a close always leaves the slot full; a bare handshake empties it
  always_comb state_n = i_load ? OUT_FULL : hs ? OUT_EMPTY : state;
  // state register
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= OUT_EMPTY;
    else state <= state_n;
  // capture a closing sum only when the slot is free this cycle, otherwise flag the drop
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_sum <= '0;
      o_cnt <= '0;
      o_overrun <= 1'b0;
    end else begin
      if (take) begin
        o_sum <= i_sum;
        o_cnt <= i_cnt;
      end
      if (i_load && !take) o_overrun <= 1'b1;
    end
endmodule

// File: rtl/mult_acc.sv
// mult_acc: sums groups of GROUP products into a valid/ready output; MULT_ACC_SAT_EN selects saturating accumulation
module mult_acc
  import mult_acc_pkg::*;
#(
  parameter int IN_W  = 12,
  parameter int GROUP = GROUP_DEF,
  parameter int ACC_W = 16,
  parameter int CW    = clog2(GROUP + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_result_valid,
  input  logic [IN_W-1:0]  i_result,
  input  logic             i_flush,
  output logic [ACC_W-1:0] o_sum,
  output logic [CW-1:0]    o_sum_count,
  output logic             o_sum_valid,
  input  logic             i_sum_ready,
  output logic             o_acc_ready,
  output logic             o_overrun
);
  logic [ACC_W-1:0] acc, acc_n;
  logic [CW-1:0] cnt, cnt_n;
  logic close;
`ifdef MULT_ACC_SAT_EN
  logic [ACC_W:0] sum_x;
  assign sum_x = {1'b0, acc} + (ACC_W + 1)'(i_result);
  assign acc_n = !i_result_valid ? acc : sum_x[ACC_W] ? '1 : sum_x[ACC_W-1:0];
`else
  assign acc_n = i_result_valid ? acc + ACC_W'(i_result) : acc;
`endif
  assign cnt_n = cnt + CW'(i_result_valid);
  assign close = (cnt_n == CW'(GROUP)) || (i_flush && cnt_n != '0);
  assign o_acc_ready = !(o_sum_valid && cnt == CW'(GROUP - 1));
  // running group sum and product count, cleared whenever a group closes
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else begin
      acc <= close ? '0 : acc_n;
      cnt <= close ? '0 : cnt_n;
    end
  mult_acc_outreg #(.W(ACC_W), .CW(CW)) u_out (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (close),
    .i_sum     (acc_n),
    .i_cnt     (cnt_n),
    .i_ready   (i_sum_ready),
    .o_sum     (o_sum),
    .o_cnt     (o_sum_count),
    .o_valid   (o_sum_valid),
    .o_overrun (o_overrun)
  );
endmodule

// File: tb/tb_mult_acc.sv
// tb_mult_acc: directed vector table, wrap/saturate check on a 12-bit instance, randomized run against a group-level model
module tb_mult_acc;
  import mult_acc_pkg::*;
  localparam int IN_W = 12;
  localparam int GROUP = 4;
  localparam int ACC_W = 16;
  localparam int ACC2_W = 12;

  logic i_clk = 0;
  logic i_rst_n = 0;
  logic rv = 0, flush = 0, ready = 0;
  logic [IN_W-1:0] res = '0;
  logic [ACC_W-1:0] o_sum;
  logic [CNT_W-1:0] o_cnt;
  logic o_valid, o_accr, o_ovr;
  logic rv2 = 0, flush2 = 0, ready2 = 0;
  logic [IN_W-1:0] res2 = '0;
  logic [ACC2_W-1:0] o_sum2;
  logic [CNT_W-1:0] o_cnt2;
  logic o_valid2, o_accr2, o_ovr2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 i_clk = ~i_clk;

  mult_acc #(.IN_W(IN_W), .GROUP(GROUP), .ACC_W(ACC_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_result_valid(rv), .i_result(res), .i_flush(flush),
    .o_sum(o_sum), .o_sum_count(o_cnt), .o_sum_valid(o_valid), .i_sum_ready(ready),
    .o_acc_ready(o_accr), .o_overrun(o_ovr));

  mult_acc #(.IN_W(IN_W), .GROUP(GROUP), .ACC_W(ACC2_W)) dut12 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_result_valid(rv2), .i_result(res2), .i_flush(flush2),
    .o_sum(o_sum2), .o_sum_count(o_cnt2), .o_sum_valid(o_valid2), .i_sum_ready(ready2),
    .o_acc_ready(o_accr2), .o_overrun(o_ovr2));

  typedef struct {
    bit r; bit v; int p; bit f; bit rdy;
    bit ev; int es; int ec; bit eo; bit ea;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit r, v, input int p, input bit f, rdy,
                     input bit ev, input int es, ec, input bit eo, ea, input int rep = 1);
    vec_t t;
    t = '{r, v, p, f, rdy, ev, es, ec, eo, ea};
    for (int i = 0; i < rep; i++) tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input bit r, v, input int p, input bit f, rdy);
    i_rst_n = !r;
    rv = v;
    res = IN_W'(p);
    flush = f;
    ready = rdy;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input bit ev, input int es, ec, input bit eo, ea);
    chk({tag, " valid"}, int'(o_valid), int'(ev));
    chk({tag, " sum"}, int'(o_sum), es);
    chk({tag, " count"}, int'(o_cnt), ec);
    chk({tag, " overrun"}, int'(o_ovr), int'(eo));
    chk({tag, " acc_ready"}, int'(o_accr), int'(ea));
  endtask

  int grp[$];
  bit m_full, m_ovr;
  int m_sum, m_cnt;

  function automatic void model_reset();
    grp.delete();
    m_full = 0;
    m_ovr = 0;
    m_sum = 0;
    m_cnt = 0;
  endfunction

  function automatic void model_step(input bit v, input int p, input bit f, input bit rdy);
    bit hs;
    longint t;
    hs = m_full && rdy;
    if (v) grp.push_back(p);
    if (grp.size() == GROUP || (f && grp.size() > 0)) begin
      t = 0;
      foreach (grp[i]) t += grp[i];
`ifdef MULT_ACC_SAT_EN
      if (t > (64'd1 << ACC_W) - 1) t = (64'd1 << ACC_W) - 1;
`else
      t = t % (64'd1 << ACC_W);
`endif
      if (!m_full || hs) begin
        m_sum = int'(t);
        m_cnt = grp.size();
        m_full = 1;
      end else m_ovr = 1;
      grp.delete();
    end else if (hs) m_full = 0;
  endfunction

  initial begin
    int exp2;
    bit v, f, rdy;
    int p;
    // reset
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    // full group with consumer ready
    add(0, 1, 125, 0, 1, 0, 0, 0, 0, 1);
    add(0, 1, 160, 0, 1, 0, 0, 0, 0, 1);
    add(0, 1, 40, 0, 1, 0, 0, 0, 0, 1);
    add(0, 1, 105, 0, 1, 1, 430, 4, 0, 1);
    add(0, 0, 0, 0, 1, 0, 430, 4, 0, 1);
    // early flush, then flush with nothing pending
    add(0, 1, 1935, 0, 1, 0, 430, 4, 0, 1);
    add(0, 0, 0, 1, 1, 1, 1935, 1, 0, 1);
    add(0, 0, 0, 0, 1, 0, 1935, 1, 0, 1);
    add(0, 0, 0, 1, 1, 0, 1935, 1, 0, 1);
    add(0, 0, 0, 0, 1, 0, 1935, 1, 0, 1);
    // backpressure, second group overruns
    add(0, 1, 100, 0, 0, 0, 1935, 1, 0, 1, 3);
    add(0, 1, 100, 0, 0, 1, 400, 4, 0, 1, 3);
    add(0, 1, 100, 0, 0, 1, 400, 4, 0, 0);
    add(0, 1, 100, 0, 0, 1, 400, 4, 1, 1);
    add(0, 0, 0, 0, 0, 1, 400, 4, 1, 1);
    // reset clears overrun and the held sum
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // back-to-back handshake with close
    add(0, 1, 100, 0, 0, 0, 0, 0, 0, 1, 3);
    add(0, 1, 100, 0, 0, 1, 400, 4, 0, 1);
    add(0, 1, 200, 0, 0, 1, 400, 4, 0, 1, 2);
    add(0, 1, 200, 0, 0, 1, 400, 4, 0, 0);
    add(0, 1, 200, 0, 1, 1, 800, 4, 0, 1);
    add(0, 0, 0, 0, 1, 0, 800, 4, 0, 1);
    // reset mid-group, then fresh group
    add(0, 1, 1, 0, 1, 0, 800, 4, 0, 1);
    add(0, 1, 2, 0, 1, 0, 800, 4, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    add(0, 1, 1, 0, 1, 0, 0, 0, 0, 1);
    add(0, 1, 2, 0, 1, 0, 0, 0, 0, 1);
    add(0, 1, 3, 0, 1, 0, 0, 0, 0, 1);
    add(0, 1, 4, 0, 1, 1, 10, 4, 0, 1);
    add(0, 0, 0, 0, 1, 0, 10, 4, 0, 1);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].p, tbl[i].f, tbl[i].rdy);
      chk_all($sformatf("row%0d", i), tbl[i].ev, tbl[i].es, tbl[i].ec, tbl[i].eo, tbl[i].ea);
    end

    // 12-bit accumulator: 4000 + 200 then flush
    drive(0, 0, 0, 0, 0);
`ifdef MULT_ACC_SAT_EN
    exp2 = 4095;
`else
    exp2 = 104;
`endif
    ready2 = 1;
    rv2 = 1;
    res2 = 12'd4000;
    @(posedge i_clk);
    #1;
    res2 = 12'd200;
    @(posedge i_clk);
    #1;
    rv2 = 0;
    res2 = '0;
    flush2 = 1;
    @(posedge i_clk);
    #1;
    flush2 = 0;
    chk("acc12 valid", int'(o_valid2), 1);
    chk("acc12 sum", int'(o_sum2), exp2);
    chk("acc12 count", int'(o_cnt2), 2);
    chk("acc12 overrun", int'(o_ovr2), 0);

    // randomized run against the group-level model
    drive(1, 0, 0, 0, 0);
    model_reset();
    for (int n = 0; n < 400; n++) begin
      v = ($urandom_range(0, 1) == 1);
      p = int'($urandom_range(0, 4095));
      f = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      model_step(v, p, f, rdy);
      drive(0, v, p, f, rdy);
      chk_all($sformatf("rand%0d", n), m_full, m_sum, m_cnt, m_ovr,
              !(m_full && grp.size() == GROUP - 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
